// File: rtl/is_uart_pkg.sv
// Shared divisor type and divisor arithmetic for the is_uart baud path.
package is_uart_pkg;

    localparam int UART_DIV_INT_W  = 16;
    localparam int UART_DIV_FRAC_W = 4;
    localparam int MIN_DIV_INT     = 2;

    typedef struct packed {
        logic [UART_DIV_INT_W-1:0]  int_part;
        logic [UART_DIV_FRAC_W-1:0] frac;
    } uart_div_t;

    // Cycles per oversample tick as fixed point with frac_w fraction bits, rounded to nearest.
    function automatic longint unsigned calc_div_fx(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned ovs,
        input int unsigned     frac_w
    );
        longint unsigned den;
        den = baud * ovs;
        return ((clk_hz << frac_w) + (den >> 1)) / den;
    endfunction

    function automatic uart_div_t calc_div(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned ovs
    );
        longint unsigned fx;
        uart_div_t       d;
        fx         = calc_div_fx(clk_hz, baud, ovs, UART_DIV_FRAC_W);
        d.int_part = UART_DIV_INT_W'(fx >> UART_DIV_FRAC_W);
        d.frac     = UART_DIV_FRAC_W'(fx);
        return d;
    endfunction

endpackage

// File: rtl/is_uart_tick_nco.sv
// Fractional tick NCO: integer down-counter plus fraction accumulator whose
// carry stretches a period by one cycle. tick_o is combinational (stage p0).
module is_uart_tick_nco
    import is_uart_pkg::*;
#(
    parameter int unsigned          DIV_INT_W  = 16,
    parameter int unsigned          DIV_FRAC_W = 4,
    parameter logic [DIV_INT_W-1:0] RST_INT    = 54
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  en_i,
    input  logic                  restart_i,
    input  logic [DIV_INT_W-1:0]  div_int_i,
    input  logic [DIV_FRAC_W-1:0] div_frac_i,
    output logic                  tick_o
);

    localparam logic [DIV_INT_W-1:0] MIN_INT = DIV_INT_W'(MIN_DIV_INT);
    localparam logic [DIV_INT_W-1:0] RST_CNT =
        ((RST_INT < MIN_INT) ? MIN_INT : RST_INT) - 1'b1;

    logic [DIV_INT_W-1:0]  cnt;
    logic [DIV_INT_W-1:0]  int_eff;
    logic [DIV_FRAC_W-1:0] acc;
    logic [DIV_FRAC_W:0]   acc_sum;

    // A divisor below 2 would leave no room for the down-count to reload.
    assign int_eff = (div_int_i < MIN_INT) ? MIN_INT : div_int_i;
    assign acc_sum = {1'b0, acc} + {1'b0, div_frac_i};
    assign tick_o  = en_i && !restart_i && (cnt == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= RST_CNT;
            acc <= '0;
        end else if (restart_i) begin
            cnt <= int_eff - 1'b1;
            acc <= '0;
        end else if (en_i) begin
            if (cnt == '0) begin
                cnt <= int_eff - 1'b1 + DIV_INT_W'(acc_sum[DIV_FRAC_W]);
                acc <= acc_sum[DIV_FRAC_W-1:0];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/is_uart_baud_gen.sv
// UART baud generator: shadowed runtime divisor, fractional tick NCO and the
// oversample stage producing registered ovs/mid/bit clock-enable strobes.
module is_uart_baud_gen
    import is_uart_pkg::*;
#(
    parameter int unsigned FAST_CLK_HZ  = 100_000_000,
    parameter int unsigned DEFAULT_BAUD = 115_200,
    parameter int unsigned OVS          = 16,
    parameter int unsigned DIV_INT_W    = 16,
    parameter int unsigned DIV_FRAC_W   = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic                    restart_i,
    input  logic                    div_load_i,
    input  logic [DIV_INT_W-1:0]    div_int_i,
    input  logic [DIV_FRAC_W-1:0]   div_frac_i,
    output logic                    div_pend_o,
    output logic                    ovs_tick_o,
    output logic                    mid_tick_o,
    output logic                    bit_tick_o,
    output logic [$clog2(OVS)-1:0]  ovs_phase_o
);

    localparam int unsigned PHASE_W = $clog2(OVS);
    localparam longint unsigned DEF_FX =
        calc_div_fx(FAST_CLK_HZ, DEFAULT_BAUD, OVS, DIV_FRAC_W);
    localparam logic [DIV_INT_W-1:0]  DEF_INT  = DIV_INT_W'(DEF_FX >> DIV_FRAC_W);
    localparam logic [DIV_FRAC_W-1:0] DEF_FRAC = DIV_FRAC_W'(DEF_FX);
    localparam logic [PHASE_W-1:0]    MID_IDX  = PHASE_W'(OVS / 2 - 1);
    localparam logic [PHASE_W-1:0]    LAST_IDX = PHASE_W'(OVS - 1);

    logic [DIV_INT_W-1:0]  act_int;
    logic [DIV_FRAC_W-1:0] act_frac;
    logic [DIV_INT_W-1:0]  shd_int;
    logic [DIV_FRAC_W-1:0] shd_frac;
    logic [DIV_INT_W-1:0]  use_int;
    logic [DIV_FRAC_W-1:0] use_frac;
    logic                  pend;
    logic                  tick_p0;
    logic [PHASE_W-1:0]    ovs_cnt;
    logic                  ovs_p1;
    logic                  mid_p1;
    logic                  bit_p1;

    // Divisor seen by the NCO: a restart takes a same-cycle load directly,
    // otherwise a pending shadow wins over the active divisor.
    always_comb begin
        use_int  = act_int;
        use_frac = act_frac;
        if (restart_i && div_load_i) begin
            use_int  = div_int_i;
            use_frac = div_frac_i;
        end else if (pend) begin
            use_int  = shd_int;
            use_frac = shd_frac;
        end
    end

    always_ff @(posedge clk_i) begin
        if (div_load_i) begin
            shd_int  <= div_int_i;
            shd_frac <= div_frac_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            act_int  <= DEF_INT;
            act_frac <= DEF_FRAC;
            pend     <= 1'b0;
        end else begin
            if (restart_i || (tick_p0 && pend)) begin
                act_int  <= use_int;
                act_frac <= use_frac;
            end
            // A load on the reload edge keeps the new value pending.
            if (restart_i) begin
                pend <= 1'b0;
            end else if (div_load_i) begin
                pend <= 1'b1;
            end else if (tick_p0) begin
                pend <= 1'b0;
            end
        end
    end

    is_uart_tick_nco #(
        .DIV_INT_W  (DIV_INT_W),
        .DIV_FRAC_W (DIV_FRAC_W),
        .RST_INT    (DEF_INT)
    ) u_nco (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .en_i       (en_i),
        .restart_i  (restart_i),
        .div_int_i  (use_int),
        .div_frac_i (use_frac),
        .tick_o     (tick_p0)
    );

    // p0 -> p1: oversample index and registered strobes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovs_cnt <= '0;
            ovs_p1  <= 1'b0;
            mid_p1  <= 1'b0;
            bit_p1  <= 1'b0;
        end else if (restart_i) begin
            ovs_cnt <= '0;
            ovs_p1  <= 1'b0;
            mid_p1  <= 1'b0;
            bit_p1  <= 1'b0;
        end else begin
            ovs_p1 <= tick_p0;
            mid_p1 <= tick_p0 && (ovs_cnt == MID_IDX);
            bit_p1 <= tick_p0 && (ovs_cnt == LAST_IDX);
            if (tick_p0) begin
                ovs_cnt <= (ovs_cnt == LAST_IDX) ? '0 : ovs_cnt + 1'b1;
            end
        end
    end

    assign div_pend_o  = pend;
    assign ovs_tick_o  = ovs_p1;
    assign mid_tick_o  = mid_p1;
    assign bit_tick_o  = bit_p1;
    assign ovs_phase_o = ovs_cnt;

endmodule

// File: tb/tb_is_uart_baud_gen.sv
// Bench for is_uart_baud_gen: vector table, directed timing sequences and
// randomized runs against a closed-form tick-time model.
module tb_is_uart_baud_gen;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        en_i;
    logic        restart_i;
    logic        div_load_i;
    logic [15:0] div_int_i;
    logic [3:0]  div_frac_i;
    logic        div_pend_o;
    logic        ovs_tick_o;
    logic        mid_tick_o;
    logic        bit_tick_o;
    logic [3:0]  ovs_phase_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic        rs;
        logic        ld;
        logic [15:0] di;
        logic [3:0]  df;
        logic        ovs;
        logic        mid;
        logic        bt;
        logic [3:0]  ph;
        logic        pend;
    } vec_t;
    vec_t vecs[$];

    // Model: within a segment started by reset or restart (acc cleared), the
    // k-th tick lands on enabled edge k*I + floor((k-1)*F/16).
    longint     m_e;
    longint     m_k;
    longint     m_int;
    longint     m_frac;
    logic       m_ovs;
    logic       m_mid;
    logic       m_bit;
    logic [3:0] m_ph;

    always #5 clk_i = ~clk_i;

    is_uart_baud_gen #(
        .FAST_CLK_HZ  (100_000_000),
        .DEFAULT_BAUD (115_200),
        .OVS          (16),
        .DIV_INT_W    (16),
        .DIV_FRAC_W   (4)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .en_i        (en_i),
        .restart_i   (restart_i),
        .div_load_i  (div_load_i),
        .div_int_i   (div_int_i),
        .div_frac_i  (div_frac_i),
        .div_pend_o  (div_pend_o),
        .ovs_tick_o  (ovs_tick_o),
        .mid_tick_o  (mid_tick_o),
        .bit_tick_o  (bit_tick_o),
        .ovs_phase_o (ovs_phase_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_e = 0; m_k = 0; m_int = 54; m_frac = 4;
        m_ovs = 1'b0; m_mid = 1'b0; m_bit = 1'b0; m_ph = 4'd0;
    endfunction

    function automatic void model_edge(input logic en, input logic rs, input logic ld,
                                       input logic [15:0] di, input logic [3:0] df);
        longint due;
        m_ovs = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
        if (rs) begin
            if (ld) begin
                m_int  = (di < 2) ? 2 : longint'(di);
                m_frac = longint'(df);
            end
            m_e = 0; m_k = 0; m_ph = 4'd0;
        end else if (en) begin
            m_e++;
            due = (m_k + 1) * m_int + ((m_k * m_frac) >> 4);
            if (m_e == due) begin
                m_k++;
                m_ovs = 1'b1;
                m_mid = ((m_k - 1) % 16) == 7;
                m_bit = ((m_k - 1) % 16) == 15;
                m_ph  = 4'(m_k % 16);
            end
        end
    endfunction

    task automatic step(input logic en, input logic rs, input logic ld,
                        input logic [15:0] di, input logic [3:0] df);
        en_i = en; restart_i = rs; div_load_i = ld; div_int_i = di; div_frac_i = df;
        @(posedge clk_i);
        #1;
        model_edge(en, rs, ld, di, df);
    endtask

    task automatic do_reset();
        en_i = 1'b0; restart_i = 1'b0; div_load_i = 1'b0; div_int_i = '0; div_frac_i = '0;
        @(negedge clk_i);
        rstn_i = 1'b0;
        #2;
        chk("rst_ovs", ovs_tick_o, 0);
        chk("rst_mid", mid_tick_o, 0);
        chk("rst_bit", bit_tick_o, 0);
        chk("rst_phase", ovs_phase_o, 0);
        chk("rst_pend", div_pend_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
    endtask

    function automatic void row(input logic en, input logic rs, input logic ld,
                                input logic [15:0] di, input logic [3:0] df,
                                input logic ovs, input logic mid, input logic bt,
                                input logic [3:0] ph, input logic pend);
        vec_t v;
        v.en = en; v.rs = rs; v.ld = ld; v.di = di; v.df = df;
        v.ovs = ovs; v.mid = mid; v.bt = bt; v.ph = ph; v.pend = pend;
        vecs.push_back(v);
    endfunction

    function automatic void quiet(input int n, input logic en, input logic [3:0] ph, input logic pend);
        for (int i = 0; i < n; i++) row(en, 1'b0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, ph, pend);
    endfunction

    function automatic void tk(input logic [3:0] ph, input logic pend);
        row(1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0, ph, pend);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int last;
        int e16;
        int first;
        rstn_i = 1'b0;
        en_i = 1'b0; restart_i = 1'b0; div_load_i = 1'b0; div_int_i = '0; div_frac_i = '0;

        // Default divisor 54.25 straight out of reset.
        do_reset();
        t = 0; e16 = 0;
        for (int e = 1; e <= 1800 && t < 32; e++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
            if (ovs_tick_o) begin
                t++;
                if (t == 1)  chk("t1_first_tick_edge", e, 54);
                if (t == 8)  chk("t1_mid_edge", e, 433);
                chk("t1_mid", mid_tick_o, 32'((t % 16) == 8));
                chk("t1_bit", bit_tick_o, 32'((t % 16) == 0));
                chk("t1_phase", ovs_phase_o, t % 16);
                if (t == 16) begin
                    chk("t1_bit_edge", e, 867);
                    e16 = e;
                end
                if (t == 32) chk("t1_bit_span", e - e16, 868);
            end
        end
        chk("t1_tick_count", t, 32);

        // int=4 frac=0: regular 4-cycle ticks, mid/bit placement, phase sweep.
        step(1'b1, 1'b1, 1'b1, 16'd4, 4'd0);
        t = 0; last = 0;
        for (int e = 1; e <= 160 && t < 33; e++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
            if (ovs_tick_o) begin
                t++;
                chk("t2_gap", e - last, 4);
                chk("t2_mid", mid_tick_o, 32'((t % 16) == 8));
                chk("t2_bit", bit_tick_o, 32'((t % 16) == 0));
                chk("t2_phase", ovs_phase_o, t % 16);
                last = e;
            end
        end
        chk("t2_tick_count", t, 33);

        // int=4 frac=8: spacing 4,4,5,4,5,...
        step(1'b1, 1'b1, 1'b1, 16'd4, 4'd8);
        t = 0;
        for (int e = 1; e <= 200 && t < 32; e++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
            if (ovs_tick_o) begin
                t++;
                if (t == 1)  chk("t3_tick1_edge", e, 4);
                if (t == 3)  chk("t3_tick3_edge", e, 13);
                if (t == 32) chk("t3_tick32_edge", e, 143);
            end
        end
        chk("t3_tick_count", t, 32);

        // Clamp: int 0 and int 1 both run at 2 cycles per tick.
        for (int d = 0; d < 2; d++) begin
            step(1'b1, 1'b1, 1'b1, 16'(d), 4'd0);
            t = 0; last = 0;
            for (int e = 1; e <= 30 && t < 6; e++) begin
                step(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
                if (ovs_tick_o) begin
                    t++;
                    chk($sformatf("t6_clamp%0d_gap", d), e - last, 2);
                    last = e;
                end
            end
            chk($sformatf("t6_clamp%0d_count", d), t, 6);
        end

        // Reset mid-bit with a load pending: everything back to defaults.
        step(1'b1, 1'b1, 1'b1, 16'd4, 4'd0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 16'd9, 4'd0);
        chk("t6_pend_before_reset", div_pend_o, 1);
        do_reset();
        first = 0;
        for (int e = 1; e <= 80 && first == 0; e++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0, 4'd0);
            if (ovs_tick_o) first = e;
        end
        chk("t6_default_after_reset", first, 54);
        chk("t6_pend_after_reset", div_pend_o, 0);

        // Vector table: pending loads, enable freeze, restarts.
        do_reset();
        row(1, 1, 1, 16'd4, 4'd0, 0, 0, 0, 4'd0, 0);
        quiet(3, 1, 4'd0, 0);
        tk(4'd1, 0);
        quiet(3, 1, 4'd1, 0);
        tk(4'd2, 0);
        row(1, 0, 1, 16'd10, 4'd0, 0, 0, 0, 4'd2, 1);
        quiet(2, 1, 4'd2, 1);
        tk(4'd3, 0);
        quiet(9, 1, 4'd3, 0);
        tk(4'd4, 0);
        quiet(7, 0, 4'd4, 0);
        quiet(9, 1, 4'd4, 0);
        tk(4'd5, 0);
        row(0, 1, 0, 16'd0, 4'd0, 0, 0, 0, 4'd0, 0);
        quiet(3, 0, 4'd0, 0);
        quiet(9, 1, 4'd0, 0);
        tk(4'd1, 0);
        row(1, 1, 1, 16'd4, 4'd0, 0, 0, 0, 4'd0, 0);
        quiet(3, 1, 4'd0, 0);
        tk(4'd1, 0);
        quiet(3, 1, 4'd1, 0);
        row(1, 1, 0, 16'd0, 4'd0, 0, 0, 0, 4'd0, 0);
        quiet(3, 1, 4'd0, 0);
        tk(4'd1, 0);
        quiet(3, 1, 4'd1, 0);
        row(1, 0, 1, 16'd6, 4'd0, 1, 0, 0, 4'd2, 1);
        quiet(3, 1, 4'd2, 1);
        tk(4'd3, 0);
        quiet(5, 1, 4'd3, 0);
        tk(4'd4, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].rs, vecs[i].ld, vecs[i].di, vecs[i].df);
            chk($sformatf("tbl%0d_ovs", i), ovs_tick_o, vecs[i].ovs);
            chk($sformatf("tbl%0d_mid", i), mid_tick_o, vecs[i].mid);
            chk($sformatf("tbl%0d_bit", i), bit_tick_o, vecs[i].bt);
            chk($sformatf("tbl%0d_phase", i), ovs_phase_o, vecs[i].ph);
            chk($sformatf("tbl%0d_pend", i), div_pend_o, vecs[i].pend);
        end

        // Randomized: divisor set with restart, random enable gaps and restarts.
        do_reset();
        for (int seg = 0; seg < 10; seg++) begin
            logic [15:0] di;
            logic [3:0]  df;
            int          len;
            di  = 16'($urandom_range(0, 9));
            df  = 4'($urandom_range(0, 15));
            len = int'($urandom_range(60, 250));
            step(1'b1, 1'b1, 1'b1, di, df);
            for (int c = 0; c < len; c++) begin
                logic en;
                logic rs;
                en = ($urandom_range(0, 3) != 0);
                rs = ($urandom_range(0, 49) == 0);
                step(en, rs, 1'b0, 16'd0, 4'd0);
                chk("rnd_ovs", ovs_tick_o, m_ovs);
                chk("rnd_mid", mid_tick_o, m_mid);
                chk("rnd_bit", bit_tick_o, m_bit);
                chk("rnd_phase", ovs_phase_o, m_ph);
                chk("rnd_pend", div_pend_o, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
